// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, ex_op encodings and divider state type for the execute stage.
package ex_stage_pkg;
   localparam int DATA_W   = 32;
   localparam int EX_OP_W  = 5;
   localparam int LSU_OP_W = 4;
   localparam int CSR_OP_W = 3;
   localparam logic [EX_OP_W-1:0] EX_OP_ADD   = 5'd0;
   localparam logic [EX_OP_W-1:0] EX_OP_SUB   = 5'd1;
   localparam logic [EX_OP_W-1:0] EX_OP_SLT   = 5'd2;
   localparam logic [EX_OP_W-1:0] EX_OP_SLTU  = 5'd3;
   localparam logic [EX_OP_W-1:0] EX_OP_AND   = 5'd4;
   localparam logic [EX_OP_W-1:0] EX_OP_OR    = 5'd5;
   localparam logic [EX_OP_W-1:0] EX_OP_NOR   = 5'd6;
   localparam logic [EX_OP_W-1:0] EX_OP_XOR   = 5'd7;
   localparam logic [EX_OP_W-1:0] EX_OP_SLL   = 5'd8;
   localparam logic [EX_OP_W-1:0] EX_OP_SRL   = 5'd9;
   localparam logic [EX_OP_W-1:0] EX_OP_SRA   = 5'd10;
   localparam logic [EX_OP_W-1:0] EX_OP_LUI   = 5'd11;
   localparam logic [EX_OP_W-1:0] EX_OP_MUL   = 5'd12;
   localparam logic [EX_OP_W-1:0] EX_OP_MULH  = 5'd13;
   localparam logic [EX_OP_W-1:0] EX_OP_MULHU = 5'd14;
   localparam logic [EX_OP_W-1:0] EX_OP_DIV   = 5'd15;
   localparam logic [EX_OP_W-1:0] EX_OP_MOD   = 5'd16;
   localparam logic [EX_OP_W-1:0] EX_OP_DIVU  = 5'd17;
   localparam logic [EX_OP_W-1:0] EX_OP_MODU  = 5'd18;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
   function automatic logic is_div(input logic [EX_OP_W-1:0] op);
      return op inside {EX_OP_DIV, EX_OP_MOD, EX_OP_DIVU, EX_OP_MODU};
   endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: ID->EX register fields; i is the consumer view, o the producer view.
interface id_stage_if;
   import ex_stage_pkg::*;
   logic [31:0]         inst;
   logic [31:0]         pc;
   logic [DATA_W-1:0]   oprand1;
   logic [DATA_W-1:0]   oprand2;
   logic [EX_OP_W-1:0]  ex_op;
   logic [LSU_OP_W-1:0] lsu_op;
   logic [DATA_W-1:0]   lsu_data;
   logic [CSR_OP_W-1:0] csr_op;
   logic [4:0]          rw_addr;
   logic                rw_en;
   modport i (input inst, pc, oprand1, oprand2, ex_op, lsu_op, lsu_data, csr_op, rw_addr, rw_en);
   modport o (output inst, pc, oprand1, oprand2, ex_op, lsu_op, lsu_data, csr_op, rw_addr, rw_en);
endinterface

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider, one quotient bit per cycle on magnitudes, signs fixed at output.
module ex_divider
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              start,
   input  logic              is_signed,
   input  logic              is_rem,
   input  logic              ack,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);
   localparam int CW = $clog2(DATA_W);
   div_state_t state, state_n;
   logic [DATA_W-1:0] quo, rem, dsr, a_abs, b_abs;
   logic [DATA_W:0]   trial;
   logic [CW-1:0]     count;
   logic              neg_q, neg_r, rem_op, fits, zero;
   assign a_abs = is_signed && dividend[DATA_W-1] ? -dividend : dividend;
   assign b_abs = is_signed && divisor[DATA_W-1] ? -divisor : divisor;
   assign zero  = divisor == '0;
   assign trial = {rem, quo[DATA_W-1]};
   assign fits  = trial >= {1'b0, dsr};
   always_comb begin
      state_n = state;
      if (flush)
         state_n = IDLE;
      else if (state == IDLE)
         state_n = start ? (zero ? DONE : BUSY) : IDLE;
      else if (state == BUSY)
         state_n = count == CW'(DATA_W-1) ? DONE : BUSY;
      else if (ack)
         state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         quo    <= '0;
         rem    <= '0;
         dsr    <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         rem_op <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && start && !flush) begin
            // divide-by-zero preloads the final answer so DONE needs no special case
            quo    <= zero ? '1 : a_abs;
            rem    <= zero ? dividend : '0;
            dsr    <= b_abs;
            count  <= '0;
            neg_q  <= is_signed && !zero && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_r  <= is_signed && !zero && dividend[DATA_W-1];
            rem_op <= is_rem;
         end else if (state == BUSY) begin
            rem   <= fits ? trial[DATA_W-1:0] - dsr : trial[DATA_W-1:0];
            quo   <= {quo[DATA_W-2:0], fits};
            count <= count + 1'b1;
         end
      end
   end
   assign busy   = state == BUSY;
   assign done   = state == DONE;
   assign result = rem_op ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU/MUL; EX_DIV_EN adds the iterative divider,
// otherwise divide ops finish in one cycle with a zero result.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ls_valid,
   output logic              ts_ready,
   input  logic              ns_ready,
   output logic              ts_valid,
   input  logic              stall,
   input  logic              flush,
   id_stage_if.i             id_info,
   output logic [DATA_W-1:0] ex_result,
   id_stage_if.o             ex_info
);
   localparam int SH_W = $clog2(DATA_W);
   logic [DATA_W-1:0] a, b, alu, mul_lo, mulh_s, mulh_u, unused_lo;
   logic [SH_W-1:0]   sh;
   logic              ack;
   assign a   = id_info.oprand1;
   assign b   = id_info.oprand2;
   assign sh  = b[SH_W-1:0];
   assign ack = ns_ready && !stall;
   assign {mulh_s, mul_lo}    = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
   assign {mulh_u, unused_lo} = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   always_comb begin
      alu = '0;
      case (id_info.ex_op)
         EX_OP_ADD:   alu = a + b;
         EX_OP_SUB:   alu = a - b;
         EX_OP_SLT:   alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         EX_OP_SLTU:  alu = {{(DATA_W-1){1'b0}}, a < b};
         EX_OP_AND:   alu = a & b;
         EX_OP_OR:    alu = a | b;
         EX_OP_NOR:   alu = ~(a | b);
         EX_OP_XOR:   alu = a ^ b;
         EX_OP_SLL:   alu = a << sh;
         EX_OP_SRL:   alu = a >> sh;
         EX_OP_SRA:   alu = $signed(a) >>> sh;
         EX_OP_LUI:   alu = b;
         EX_OP_MUL:   alu = mul_lo;
         EX_OP_MULH:  alu = mulh_s;
         EX_OP_MULHU: alu = mulh_u;
         default:     alu = '0;
      endcase
   end
`ifdef EX_DIV_EN
   logic              div_op, busy, done;
   logic [DATA_W-1:0] div_res;
   assign div_op = ls_valid && is_div(id_info.ex_op);
   ex_divider u_div (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .start     (div_op),
      .is_signed (id_info.ex_op == EX_OP_DIV || id_info.ex_op == EX_OP_MOD),
      .is_rem    (id_info.ex_op == EX_OP_MOD || id_info.ex_op == EX_OP_MODU),
      .ack       (ack),
      .dividend  (a),
      .divisor   (b),
      .busy      (busy),
      .done      (done),
      .result    (div_res)
   );
   // ID->EX holds the divide op until the result is handed on
   assign ts_valid  = ls_valid && !stall && !flush && (!div_op || done);
   assign ts_ready  = div_op ? (done && !busy && ack) : (!ls_valid || ack);
   assign ex_result = div_op ? div_res : alu;
`else
   logic unused_clk;
   assign unused_clk = clk ^ rst;
   assign ts_valid   = ls_valid && !stall && !flush;
   assign ts_ready   = !ls_valid || ack;
   assign ex_result  = alu;
`endif
   assign ex_info.inst     = id_info.inst;
   assign ex_info.pc       = id_info.pc;
   assign ex_info.oprand1  = id_info.oprand1;
   assign ex_info.oprand2  = id_info.oprand2;
   assign ex_info.ex_op    = id_info.ex_op;
   assign ex_info.lsu_op   = id_info.lsu_op;
   assign ex_info.lsu_data = id_info.lsu_data;
   assign ex_info.csr_op   = id_info.csr_op;
   assign ex_info.rw_addr  = id_info.rw_addr;
   assign ex_info.rw_en    = id_info.rw_en;
endmodule
